board_input_ctrl: RTL

- Input side of the FPGA board wrapper. Synchronizes and debounces the push-buttons (KEY, active-low on board) and slide switches (SW).
- Produces one-cycle press pulses, including a single-step pulse for the CPU clock-enable path.
- Exposes a small memory-mapped read port so the RISC-V core can read board inputs, complementing the display/LED output path.

---
 rtl/board_io_pkg.sv | 18 +
 rtl/debounce_bit.sv | 42 ++++
 rtl/board_input_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared constants for the board input path: register offsets, default
// debounce interval and read-data width.
package board_io_pkg;

  localparam int RD_W             = 32;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam logic [3:0] REG_SW   = 4'h0;
  localparam logic [3:0] REG_KEY  = 4'h4;
  localparam logic [3:0] REG_EVT  = 4'h8;
  localparam logic [3:0] REG_STEP = 4'hC;

  // Byte offsets are word aligned; only bits [3:2] pick the register.
  function automatic logic [1:0] reg_word(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One board input bit: 2-flop synchronizer followed by a saturating stability
// counter that only accepts a new level after DEBOUNCE_CYCLES stable samples.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Polarity is fixed at the synchronizer input so that the reset value 0
  // of both flops always means "inactive" (released, for buttons).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw ^ INVERT;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_ctrl.sv
// Board input wrapper: debounced keys and switches, press pulses, sticky
// press events, single-step counter and a small memory-mapped read port.
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int STEP_KEY        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_SW-1:0]   sw_level,
  output logic [N_KEYS-1:0] key_press,
  output logic              step_pulse,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [RD_W-1:0]   rd_data
);

  logic [N_KEYS-1:0] key_level_d;
  logic [N_KEYS-1:0] evt;
  logic [N_KEYS-1:0] evt_clr;
  logic [N_KEYS-1:0] evt_next;
  logic [RD_W-1:0]   step_cnt;
  logic [RD_W-1:0]   rd_mux;
  logic [1:0]        rd_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^rd_addr[1:0];
  assign rd_word         = reg_word(rd_addr);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (key_n[i]),
      .level(key_level[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (sw[i]),
      .level(sw_level[i])
    );
  end

  assign key_press  = key_level & ~key_level_d;
  assign step_pulse = key_press[STEP_KEY];

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      REG_SW[3:2]:  rd_mux[N_SW-1:0]   = sw_level;
      REG_KEY[3:2]: rd_mux[N_KEYS-1:0] = key_level;
      REG_EVT[3:2]: rd_mux[N_KEYS-1:0] = evt;
      default:      rd_mux             = step_cnt;
    endcase
  end

  // A read clears only the bits it returned; a press in the same cycle is
  // OR-ed back in so that event is not lost.
  always_comb begin
    evt_clr = '0;
    if (rd_en && (rd_word == REG_EVT[3:2])) begin
      evt_clr = evt;
    end
    evt_next = (evt & ~evt_clr) | key_press;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_level_d <= '0;
      evt         <= '0;
      step_cnt    <= '0;
      rd_data     <= '0;
    end else begin
      key_level_d <= key_level;
      evt         <= evt_next;
      if (step_pulse) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule
